instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  IF stage of the RISC-V pipeline. Owns the PC, fetches words from instruction memory over a req/ack
//  interface, and buffers them in a small FIFO. Presents {instr, pc, opcode} to decode with a valid/ready
//  handshake; decode drives Immediate_Unit from id_op_o/id_instr_o. Accepts PC redirects (branch/jump/JALR)
//  from EX and discards stale fetches.
// PARAMETERS
//  RESET_PC    32'h0040_0000  PC of the first fetch after reset
//  FIFO_DEPTH  2              fetch buffer entries; legal values 2 or 4
// PORTS
//  clk            input   1   clock; all state updates on its rising edge
//  reset          input   1   synchronous, active-high reset
//  imem_req_o     output  1   fetch request; held high with imem_addr_o stable until acked
//  imem_addr_o    output  32  fetch byte address, bits [1:0] always 0
//  imem_ack_i     input   1   request accepted; imem_rdata_i valid this cycle; may assert in the cycle req rises
//  imem_rdata_i   input   32  fetched instruction word
//  redirect_i     input   1   one-cycle pulse: flush and restart fetching at redirect_pc_i
//  redirect_pc_i  input   32  new PC; bits [1:0] forced to 0 internally
//  id_valid_o     output  1   FIFO head valid toward decode
//  id_ready_i     input   1   decode accepts the head; a transfer occurs when valid&&ready
//  id_instr_o     output  32  head instruction; 32'h0000_0013 (NOP) when id_valid_o=0
//  id_pc_o        output  32  head PC; 0 when id_valid_o=0
//  id_op_o        output  7   id_instr_o[6:0]
// BEHAVIOUR
//  Reset (any cycle, overrides all inputs): pc<=RESET_PC, FIFO emptied, state<=IDLE, imem_ack_i ignored.
//   During and after reset: imem_req_o=0, id_valid_o=0, id_instr_o=NOP, id_pc_o=0.
//  FSM states: IDLE (no request), FETCH (request for current pc), DROP (request for a stale pc).
//   IDLE -> FETCH when FIFO count < FIFO_DEPTH, which includes the first cycle after reset deasserts.
//   FETCH & ack & !redirect: push {rdata, pc}, pc<=pc+4 (32-bit wrap, no trap).
//    Stay in FETCH if count after this cycle's push/pop < FIFO_DEPTH, else go IDLE.
//   FETCH & !ack & redirect: pc<=redirect_pc, go DROP. The address must stay stable until ack.
//   FETCH & ack & redirect: discard rdata, pc<=redirect_pc, stay FETCH.
//   DROP & ack: discard rdata, go FETCH with the new pc. Redirect in DROP: update pc, stay DROP.
//   IDLE & redirect: pc<=redirect_pc, go FETCH.
//  imem_req_o=1 in FETCH and DROP. imem_addr_o = pc in FETCH, or the latched stale address in DROP.
//  Latency: ack in cycle N -> id_valid_o=1 in cycle N+1 (head registered, no bypass).
//   With zero-wait memory and ready held high: 1 instr/cycle steady state.
//  Redirect: FIFO flushed at the edge; id_valid_o=0 the next cycle. If valid&&ready coincides with redirect,
//   the head is still consumed this cycle (decode owns it), and the flush removes the rest.
//  Full FIFO: no new request is issued (req issue uses count, with no pop bypass). An in-flight FETCH is never
//   abandoned. FIFO sized so one pending ack always fits: a push is allowed when full only with a same-cycle pop,
//   otherwise it is an assertion failure.
//  Empty FIFO: id_valid_o=0; id_ready_i has no effect.
//  Simultaneous push and pop: count unchanged; ordering preserved.
// STRUCTURE
//  Shared header riscv_defines.vh: opcode constants OP_IMM 7'h13, LOAD 7'h03, JALR 7'h67, LUI 7'h37,
//   STORE 7'h23, BRANCH 7'h63, JAL 7'h6F; INSTR_NOP 32'h0000_0013; FSM state encodings.
//  Sub-module fetch_fifo: parameterised {instr,pc} FIFO with push/pop/flush/count.
//   Ring-buffer pointers wrap modulo FIFO_DEPTH.
//  Top level: PC register, FSM, stale-address latch, output muxing.
// TESTING
//  1 Reset release, zero-wait mem, ready=1 -> addrs 0x00400000,04,08... on consecutive cycles; first id_valid 2 cycles after reset low.
//  2 ready=0 for 6 cycles -> FIFO fills to FIFO_DEPTH, req drops; ready=1 -> instrs delivered in order, no loss or duplicates.
//  3 3-cycle ack latency, redirect to 0x00400101 mid-wait -> addr held until ack, word discarded, next addr 0x00400100.
//  4 Redirect in same cycle as ack and as a valid&&ready pop -> popped instr kept, acked word dropped, id_valid=0 next cycle.
//  5 Assert reset with FIFO full and a request pending -> next cycle req=0, id_valid=0, id_instr=0x00000013, pc restarts at RESET_PC.
//  6 pc=0xFFFFFFFC fetch -> next addr 0x00000000; id_op_o tracks id_instr_o[6:0] for each opcode in riscv_defines.vh.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the IF stage: RISC-V opcodes, the NOP word, FSM states
// and the fetch-buffer entry layout.
package instruction_fetch_stage_pkg;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_fifo.sv
// Ring-buffer FIFO of {instr, pc} entries with push/pop/flush and an occupancy count.
module instruction_fetch_stage_fifo
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  fetch_entry_t                   push_data,
  input  logic                           pop,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH + 1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             full;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count != '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && push) mem[wr_ptr] <= push_data;
  end

  // A full buffer can only accept a word in the same cycle its head leaves.
  push_fits: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && full && !do_pop));

endmodule

// File: rtl/instruction_fetch_stage.sv
// RISC-V IF stage: PC register, imem req/ack FSM with stale-fetch discard,
// fetch buffer and valid/ready presentation of {instr, pc, opcode} to decode.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [6:0]  id_op_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      pc;
  logic [31:0]      pc_next;
  logic [31:0]      stale_addr;
  logic [31:0]      stale_addr_next;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_after;
  logic             push;
  logic             pop;
  logic             valid;
  fetch_entry_t     head;

  assign redirect_pc = word_align(redirect_pc_i);
  assign valid       = !reset && (count != '0);
  assign pop         = valid && id_ready_i;
  // Occupancy after an accepted fetch word lands alongside this cycle's pop.
  assign count_after = {1'b0, count} + 1'b1 - {{CNT_W{1'b0}}, pop};

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    stale_addr_next = stale_addr;
    push            = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_i) begin
          pc_next    = redirect_pc;
          state_next = FETCH;
        end else if (count < CNT_W'(FIFO_DEPTH)) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack_i && redirect_i) begin
          pc_next = redirect_pc;
        end else if (imem_ack_i) begin
          push    = 1'b1;
          pc_next = pc + 32'd4;
          if (count_after >= (CNT_W + 1)'(FIFO_DEPTH)) state_next = IDLE;
        end else if (redirect_i) begin
          // The outstanding request keeps its address; only its data is dropped.
          stale_addr_next = pc;
          pc_next         = redirect_pc;
          state_next      = DROP;
        end
      end
      DROP: begin
        if (redirect_i) pc_next = redirect_pc;
        if (imem_ack_i) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      stale_addr <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      stale_addr <= stale_addr_next;
    end
  end

  instruction_fetch_stage_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_i),
    .push      (push),
    .push_data ('{instr: imem_rdata_i, pc: pc}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign imem_req_o  = !reset && (state != IDLE);
  assign imem_addr_o = (state == DROP) ? stale_addr : pc;
  assign id_valid_o  = valid;
  assign id_instr_o  = valid ? head.instr : INSTR_NOP;
  assign id_pc_o     = valid ? head.pc : '0;
  assign id_op_o     = id_instr_o[6:0];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a memory model with programmable
// ack latency, a fetch-stream model feeding an expected queue, and directed scenarios.
module tb_instruction_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        req;
  logic [31:0] addr;
  logic        ack      = 1'b0;
  logic [31:0] rdata    = '0;
  logic        redirect = 1'b0;
  logic [31:0] rpc      = '0;
  logic        valid;
  logic        ready    = 1'b1;
  logic [31:0] instr;
  logic [31:0] pc_o;
  logic [6:0]  op;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned lat      = 0;
  int unsigned pops     = 0;
  exp_t        exp_q[$];

  instruction_fetch_stage #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_ack_i    (ack),
    .imem_rdata_i  (rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .id_valid_o    (valid),
    .id_ready_i    (ready),
    .id_instr_o    (instr),
    .id_pc_o       (pc_o),
    .id_op_o       (op)
  );

  initial forever #5 clk = ~clk;

  // Memory contents: the low address bits pick one of the decode opcodes.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] o;
    case (a[4:2])
      3'd0:    o = 7'h13;
      3'd1:    o = 7'h03;
      3'd2:    o = 7'h67;
      3'd3:    o = 7'h37;
      3'd4:    o = 7'h23;
      3'd5:    o = 7'h63;
      3'd6:    o = 7'h6F;
      default: o = 7'h33;
    endcase
    return {a[24:0], o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory: ack after 'lat' wait cycles; spurious acks while reset is high.
  initial begin
    int unsigned cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        ack = 1'b1; rdata = 32'hDEAD_BEEF; cnt = 0;
      end else if (!req) begin
        ack = 1'b0; cnt = 0;
      end else if (cnt >= lat) begin
        ack = 1'b1; rdata = mem_word(addr); cnt = 0;
      end else begin
        ack = 1'b0; cnt++;
      end
    end
  end

  // Monitor: models the fetch stream, fills the expected queue, checks every pop.
  initial begin
    logic [31:0] model_pc;
    logic [31:0] prev_addr;
    logic        prev_pend;
    logic        stale;
    exp_t        e;
    model_pc = RESET_PC; prev_addr = '0; prev_pend = 1'b0; stale = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        model_pc = RESET_PC; prev_pend = 1'b0; stale = 1'b0;
      end else begin
        if (req) check("addr_align", 32'(addr[1:0]), 32'd0);
        if (req && !stale) check("fetch_addr", addr, model_pc);
        if (prev_pend && req) check("addr_stable", addr, prev_addr);
        if (valid && ready) begin
          check("pop_has_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("id_instr", instr, e.instr);
            check("id_pc", pc_o, e.pc);
            check("id_op", 32'(op), 32'(e.instr[6:0]));
            pops++;
          end
        end
        if (req && ack) begin
          if (!redirect && !stale) begin
            exp_q.push_back('{instr: mem_word(model_pc), pc: model_pc});
            model_pc = model_pc + 32'd4;
          end
          stale = 1'b0;
        end else if (req && redirect) begin
          stale = 1'b1;
        end
        if (redirect) begin
          model_pc = rpc & ~32'h3;
          exp_q.delete();
        end
        prev_pend = req && !ack;
        prev_addr = addr;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a0;
    logic        found;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(req), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc_o, 32'd0);

    // 1: release reset, zero-wait memory, decode always ready
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t1_idle_req", 32'(req), 32'd0);
    check("t1_idle_valid", 32'(valid), 32'd0);
    @(negedge clk);
    check("t1_req", 32'(req), 32'd1);
    check("t1_addr0", addr, 32'h0040_0000);
    check("t1_valid_lat", 32'(valid), 32'd0);
    @(negedge clk);
    check("t1_first_valid", 32'(valid), 32'd1);
    check("t1_addr1", addr, 32'h0040_0004);
    check("t1_first_pc", pc_o, 32'h0040_0000);
    @(negedge clk);
    check("t1_addr2", addr, 32'h0040_0008);
    repeat (6) @(negedge clk);

    // 2: back-pressure fills the buffer and stops requests
    @(posedge clk); #1 ready = 1'b0;
    repeat (6) @(negedge clk);
    check("t2_req_dropped", 32'(req), 32'd0);
    check("t2_valid_held", 32'(valid), 32'd1);
    @(posedge clk); #1 ready = 1'b1;
    repeat (8) @(negedge clk);

    // 3: slow memory, redirect while a request waits
    @(posedge clk); #1 lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req && ack) begin found = 1'b1; break; end
    end
    check("t3_sync", 32'(found), 32'd1);
    @(posedge clk); #1 a0 = addr;
    @(posedge clk); #1 redirect = 1'b1; rpc = 32'h0040_0101;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("t3_hold_addr_a", addr, a0);
    check("t3_hold_req", 32'(req), 32'd1);
    @(negedge clk);
    check("t3_hold_addr_b", addr, a0);
    check("t3_stale_ack", 32'(ack), 32'd1);
    @(negedge clk);
    check("t3_new_addr", addr, 32'h0040_0100);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid) begin found = 1'b1; break; end
    end
    check("t3_valid_seen", 32'(found), 32'd1);
    check("t3_first_new_pc", pc_o, 32'h0040_0100);

    // 4: redirect coinciding with an ack and a head transfer
    @(posedge clk); #1 lat = 0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1 redirect = 1'b1; rpc = 32'h0040_0200;
    @(negedge clk);
    check("t4_pre_valid", 32'(valid), 32'd1);
    check("t4_pre_ack", 32'(ack), 32'd1);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("t4_flush_valid", 32'(valid), 32'd0);
    check("t4_flush_instr", instr, NOP);
    check("t4_flush_pc", pc_o, 32'd0);
    check("t4_new_addr", addr, 32'h0040_0200);

    // 5: reset with buffered data and a pending request
    @(posedge clk); #1 ready = 1'b0; lat = 4;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid && req && !ack) begin found = 1'b1; break; end
    end
    check("t5_pending", 32'(found), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("t5_rst_req", 32'(req), 32'd0);
    check("t5_rst_valid", 32'(valid), 32'd0);
    check("t5_rst_instr", instr, NOP);
    check("t5_rst_pc", pc_o, 32'd0);
    @(posedge clk); #1 reset = 1'b0; ready = 1'b1; lat = 0;
    @(negedge clk);
    check("t5_idle_req", 32'(req), 32'd0);
    check("t5_idle_valid", 32'(valid), 32'd0);
    @(negedge clk);
    check("t5_restart_addr", addr, RESET_PC);

    // 6: PC wrap at the top of the address space, opcode coverage
    repeat (3) @(negedge clk);
    @(posedge clk); #1 redirect = 1'b1; rpc = 32'hFFFF_FFFE;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("t6_top_addr", addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("t6_wrap_addr", addr, 32'h0000_0000);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1 ready = (i % 3) != 0;
    end
    @(posedge clk); #1 ready = 1'b1;
    repeat (10) @(negedge clk);

    check("pops_seen", 32'(pops >= 20), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
